// File: rtl/delay_line_mc.sv
// delay_line_mc: multi-channel tapped delay line with a runtime-selectable
// depth and a saturating fill counter. All channels shift together on i_ena.
// Every physical stage is visible on o_taps. o_data is the stage chosen by the
// registered depth.
module delay_line_mc #(
  parameter int gp_data_width  = 8,
  parameter int gp_nr_channels = 2,
  parameter int gp_max_stages  = 8,
  localparam int c_dw = $clog2(gp_max_stages + 1)
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst,
  input  logic                                              i_ena,
  input  logic                                              i_flush,
  input  logic [c_dw-1:0]                                   i_depth,
  input  logic [gp_nr_channels*gp_data_width-1:0]           i_data,
  output logic [gp_nr_channels*gp_data_width-1:0]           o_data,
  output logic [gp_max_stages*gp_nr_channels*gp_data_width-1:0] o_taps,
  output logic [c_dw-1:0]                                   o_fill_cnt,
  output logic                                              o_shift_done
);

  localparam int c_sw = gp_nr_channels * gp_data_width;

  // Requested depth 0 means one stage.
  // Requests beyond the physical length are capped at the physical length.
  function automatic logic [c_dw-1:0] f_clamp(input logic [c_dw-1:0] d);
    logic [c_dw-1:0] v;
    if (d == {c_dw{1'b0}}) begin
      v = {{(c_dw-1){1'b0}}, 1'b1};
    end else if (d > c_dw'(gp_max_stages)) begin
      v = c_dw'(gp_max_stages);
    end else begin
      v = d;
    end
    return v;
  endfunction

  logic [c_sw-1:0] r_stage [gp_max_stages];
  logic [c_dw-1:0] r_fill;
  logic [c_dw-1:0] r_depth;
  logic [c_dw-1:0] w_depth_cl;
  logic [c_sw-1:0] w_data;

  assign w_depth_cl = f_clamp(i_depth);

  // Stage data, fill counter and depth register.
  // Priority is reset, then flush, then depth change, then shift.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      for (int k = 0; k < gp_max_stages; k++) begin
        r_stage[k] <= '0;
      end
      r_fill  <= '0;
      r_depth <= w_depth_cl;
    end else begin
      r_depth <= w_depth_cl;
      if (i_ena) begin
        r_stage[0] <= i_data;
        for (int k = 1; k < gp_max_stages; k++) begin
          r_stage[k] <= r_stage[k-1];
        end
      end else begin
        for (int k = 0; k < gp_max_stages; k++) begin
          r_stage[k] <= r_stage[k];
        end
      end
      // A depth change restarts fill tracking but keeps the stored samples.
      if (w_depth_cl != r_depth) begin
        r_fill <= '0;
      end else if (i_ena && (r_fill < r_depth)) begin
        r_fill <= r_fill + {{(c_dw-1){1'b0}}, 1'b1};
      end else begin
        r_fill <= r_fill;
      end
    end
  end

  // Output mux: one-hot OR-select of stage r_depth-1. Adds no register stage.
  always_comb begin
    w_data = '0;
    for (int k = 0; k < gp_max_stages; k++) begin
      w_data = w_data | ({c_sw{r_depth == c_dw'(k + 1)}} & r_stage[k]);
    end
  end

  genvar g_k;
  generate
    for (g_k = 0; g_k < gp_max_stages; g_k++) begin : g_taps
      assign o_taps[g_k*c_sw +: c_sw] = r_stage[g_k];
    end
  endgenerate

  assign o_data       = w_data;
  assign o_fill_cnt   = r_fill;
  assign o_shift_done = (r_fill == r_depth);

endmodule
